// File: rtl/dot_product_folded_stream.sv
// dot_product_folded_stream
//
// This block is a streaming signed fixed-point dot-product engine.
// Each accepted beat is a pair of full-width row vectors. A beat is split into
// FOLDS = NO_OF_UNITS/LANES slices, and one slice is issued per cycle starting
// with the MSB slice. Each slice passes through three registered stages:
// LANES multipliers (P), an adder tree (T), and the accumulator (A).
// After max(total,1) beats the block converts the accumulator and presents it
// behind an output handshake.
//
// Optional feature, selected by the macro DOT_SATURATE_EN:
//   defined   : the result saturates to the signed ELEM_W range, and sat_flag
//               reports clipping.
//   undefined : the result is accumulator[ELEM_W-1:0], and sat_flag is 0.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   in_valid/in_ready   input handshake for one row pair (beat)
//   first_row_input     row A, element 0 in the MSBs
//   second_row_input    row B, element 0 in the MSBs
//   total               beats per dot product, sampled on the first beat (0 -> 1)
//   dot_product_output  result, held while out_valid is high
//   out_valid/out_ready output handshake
//   sat_flag            result was clipped (saturating build only)
//   busy                FSM is not in IDLE
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for the first beat; in_ready high
// RUN   | issuing one slice per cycle; may accept the next beat on the last fold
// WAIT  | more beats are due but none has arrived yet; in_ready high, no issue
// DRAIN | three cycles while the P/T/A pipeline empties into the accumulator
// OUT   | result presented; held until out_ready

module dot_product_folded_stream #(
    parameter int ELEM_W      = 32,
    parameter int NO_OF_UNITS = 256,
    parameter int LANES       = 64,
    parameter int ACC_W       = 2*ELEM_W+16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ELEM_W*NO_OF_UNITS-1:0] first_row_input,
    input  logic [ELEM_W*NO_OF_UNITS-1:0] second_row_input,
    input  logic [31:0]                   total,
    output logic [ELEM_W-1:0]             dot_product_output,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          sat_flag,
    output logic                          busy
);

    localparam int FOLDS  = NO_OF_UNITS / LANES;
    localparam int FOLD_W = (FOLDS > 1) ? $clog2(FOLDS) : 1;
    localparam int PW     = 2*ELEM_W;
    localparam int TW     = PW + $clog2(LANES);
    localparam int ROW_W  = ELEM_W*NO_OF_UNITS;
    localparam logic [FOLD_W-1:0] LAST_FOLD = FOLD_W'(FOLDS-1);

    typedef enum logic [2:0] {IDLE, RUN, WAIT, DRAIN, OUT} state_t;

    state_t              state_q, state_n;
    logic [FOLD_W-1:0]   fold_q, fold_n;
    logic [31:0]         beats_q, beats_n;
    logic [1:0]          drain_q, drain_n;
    logic                in_ready_n;
    logic                accept, load, clear_acc, issue, emit;

    logic [ROW_W-1:0]    row_a_q, row_b_q;
    logic signed [PW-1:0] prod [LANES];
    logic signed [PW-1:0] p_q  [LANES];
    logic                p_v;
    logic signed [TW-1:0] tree_sum, t_q;
    logic                t_v;
    logic [ACC_W-1:0]    acc_q;
    logic [ELEM_W-1:0]   conv;
    logic                conv_sat;
    int                  idx;

    // Next-state logic. The handshake outputs are registered, so in_ready is
    // predicted from the next state, the next fold and the next beat count.
    always_comb begin
        state_n   = state_q;
        fold_n    = fold_q;
        beats_n   = beats_q;
        drain_n   = drain_q;
        load      = 1'b0;
        clear_acc = 1'b0;
        issue     = 1'b0;
        emit      = 1'b0;
        accept    = in_valid && in_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n   = RUN;
                    fold_n    = '0;
                    beats_n   = (total == 32'd0) ? 32'd1 : total;
                    load      = 1'b1;
                    clear_acc = 1'b1;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (fold_q == LAST_FOLD) begin
                    if (beats_q > 32'd1) begin
                        if (accept) begin
                            fold_n  = '0;
                            beats_n = beats_q - 32'd1;
                            load    = 1'b1;
                        end else begin
                            state_n = WAIT;
                        end
                    end else begin
                        state_n = DRAIN;
                        drain_n = 2'd2;
                    end
                end else begin
                    fold_n = fold_q + FOLD_W'(1);
                end
            end
            WAIT: begin
                if (accept) begin
                    state_n = RUN;
                    fold_n  = '0;
                    beats_n = beats_q - 32'd1;
                    load    = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_n = OUT;
                    emit    = 1'b1;
                end else begin
                    drain_n = drain_q - 2'd1;
                end
            end
            OUT: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        in_ready_n = (state_n == IDLE) || (state_n == WAIT) ||
                     ((state_n == RUN) && (fold_n == LAST_FOLD) && (beats_n > 32'd1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= IDLE;
            fold_q             <= '0;
            beats_q            <= '0;
            drain_q            <= '0;
            in_ready           <= 1'b0;
            out_valid          <= 1'b0;
            busy               <= 1'b0;
            dot_product_output <= '0;
            sat_flag           <= 1'b0;
        end else begin
            state_q   <= state_n;
            fold_q    <= fold_n;
            beats_q   <= beats_n;
            drain_q   <= drain_n;
            in_ready  <= in_ready_n;
            out_valid <= (state_n == OUT);
            busy      <= (state_n != IDLE);
            if (emit) begin
                dot_product_output <= conv;
                sat_flag           <= conv_sat;
            end
        end
    end

    // Slice `fold` covers elements fold*LANES .. fold*LANES+LANES-1. Element 0
    // sits in the MSBs, so fold 0 is the MSB slice.
    always_comb begin
        idx = 0;
        for (int l = 0; l < LANES; l++) begin
            idx     = (NO_OF_UNITS - 1 - (int'(fold_q)*LANES + l)) * ELEM_W;
            prod[l] = PW'($signed(row_a_q[idx +: ELEM_W])) *
                      PW'($signed(row_b_q[idx +: ELEM_W]));
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            tree_sum = tree_sum + TW'(p_q[l]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_a_q <= '0;
            row_b_q <= '0;
            for (int l = 0; l < LANES; l++) p_q[l] <= '0;
            p_v     <= 1'b0;
            t_q     <= '0;
            t_v     <= 1'b0;
            acc_q   <= '0;
        end else begin
            if (load) begin
                row_a_q <= first_row_input;
                row_b_q <= second_row_input;
            end
            p_v <= issue;
            if (issue) begin
                for (int l = 0; l < LANES; l++) p_q[l] <= prod[l];
            end
            t_v <= p_v;
            if (p_v) t_q <= tree_sum;
            // Clearing happens only on the first beat, and the pipeline is
            // always empty at that point, so the clear never races an add.
            if (clear_acc) begin
                acc_q <= '0;
            end else if (t_v) begin
                acc_q <= acc_q + {{(ACC_W-TW){t_q[TW-1]}}, t_q};
            end
        end
    end

`ifdef DOT_SATURATE_EN
    // The value fits in ELEM_W signed bits when every bit from the ELEM_W-1
    // sign position upward matches.
    always_comb begin
        conv     = acc_q[ELEM_W-1:0];
        conv_sat = 1'b0;
        if (!((&acc_q[ACC_W-1:ELEM_W-1]) || ~(|acc_q[ACC_W-1:ELEM_W-1]))) begin
            conv_sat = 1'b1;
            conv     = acc_q[ACC_W-1] ? {1'b1, {(ELEM_W-1){1'b0}}}
                                      : {1'b0, {(ELEM_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        conv     = acc_q[ELEM_W-1:0];
        conv_sat = 1'b0;
    end
`endif

endmodule

// File: tb/tb_dot_product_folded_stream.sv
module tb_dot_product_folded_stream;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] first_row_input = '0;
    logic [255:0] second_row_input = '0;
    logic [31:0]  total = 32'd1;
    logic [31:0]  dot_product_output;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         sat_flag;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int acc_edges [64];

    dot_product_folded_stream #(
        .ELEM_W(32), .NO_OF_UNITS(8), .LANES(2)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .first_row_input(first_row_input), .second_row_input(second_row_input),
        .total(total), .dot_product_output(dot_product_output),
        .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Edge index k means the k-th rising edge; accepts are logged by edge index.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready && n_acc < 64) begin
            acc_edges[n_acc] <= cyc + 1;
            n_acc <= n_acc + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic [31:0]  tot;
        logic [31:0]  exp_val;
        logic         exp_sat;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [255:0] row8(input int e0, input int e1, input int e2,
                                          input int e3, input int e4, input int e5,
                                          input int e6, input int e7);
        logic [255:0] r;
        int e [8];
        e = '{e0, e1, e2, e3, e4, e5, e6, e7};
        r = '0;
        for (int i = 0; i < 8; i++) r[(7-i)*32 +: 32] = e[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out at edge %0d", name, cyc);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout("wait_in_ready");
    endtask

    // Returns the edge index at which out_valid was first seen high; also
    // counts cycles where in_ready was high while waiting.
    task automatic wait_out(output int edge_idx, output int ready_seen, output bit ok);
        ok = 1'b0;
        ready_seen = 0;
        edge_idx = 0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                edge_idx = cyc;
                break;
            end
            if (in_ready !== 1'b0) ready_seen++;
            @(negedge clk);
        end
        if (!ok) timeout("wait_out_valid");
    endtask

    task automatic take_output(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_valid_after_hs"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready_after_hs"}, 64'(in_ready), 64'd1);
        chk({tag, "_busy_after_hs"}, 64'(busy), 64'd0);
    endtask

    task automatic run_single(input string tag, input logic [255:0] a, input logic [255:0] b,
                              input logic [31:0] tot, input logic [31:0] exp_val,
                              input logic exp_sat, input int stall);
        bit ok;
        int acc_edge, out_edge, rdy, bad;
        wait_ready(ok);
        if (!ok) return;
        first_row_input  = a;
        second_row_input = b;
        total            = tot;
        in_valid         = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        acc_edge = cyc;
        total    = 32'd77;
        wait_out(out_edge, rdy, ok);
        if (!ok) return;
        chk({tag, "_latency"}, 64'(out_edge - acc_edge), 64'd7);
        chk({tag, "_in_ready_low_run"}, 64'(rdy), 64'd0);
        chk({tag, "_result"}, 64'(dot_product_output), 64'(exp_val));
        chk({tag, "_sat"}, 64'(sat_flag), 64'(exp_sat));
        chk({tag, "_in_ready_out"}, 64'(in_ready), 64'd0);
        if (stall > 0) begin
            bad = 0;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || dot_product_output !== exp_val ||
                    sat_flag !== exp_sat || in_ready !== 1'b0) bad++;
            end
            chk({tag, "_out_hold_stall"}, 64'(bad), 64'd0);
        end
        take_output(tag);
    endtask

    // Three beats of A=1..8, B=2; optional idle gap before the third beat.
    task automatic run_three(input string tag, input int gap);
        bit ok;
        int base, out_edge, rdy, bad;
        wait_ready(ok);
        if (!ok) return;
        base             = n_acc;
        first_row_input  = row8(1, 2, 3, 4, 5, 6, 7, 8);
        second_row_input = row8(2, 2, 2, 2, 2, 2, 2, 2);
        total            = 32'd3;
        in_valid         = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (n_acc >= base + 1) total = 32'd1;
            if (gap > 0 && n_acc >= base + 2) begin ok = 1'b1; break; end
            if (gap == 0 && n_acc >= base + 3) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
        if (!ok) begin timeout({tag, "_accepts"}); return; end
        chk({tag, "_gap_1_2"}, 64'(acc_edges[base+1] - acc_edges[base]), 64'd4);
        if (gap > 0) begin
            wait_ready(ok);
            if (!ok) return;
            bad = 0;
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                if (in_ready !== 1'b1 || busy !== 1'b1) bad++;
            end
            chk({tag, "_wait_ready_busy"}, 64'(bad), 64'd0);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk({tag, "_third_accepted"}, 64'(n_acc - base), 64'd3);
        end
        chk({tag, "_gap_2_3"}, 64'(acc_edges[base+2] - acc_edges[base+1]), 64'(4 + gap));
        wait_out(out_edge, rdy, ok);
        if (!ok) return;
        chk({tag, "_latency"}, 64'(out_edge - acc_edges[base+2]), 64'd7);
        chk({tag, "_in_ready_low_run"}, 64'(rdy), 64'd0);
        chk({tag, "_result"}, 64'(dot_product_output), 64'd216);
        chk({tag, "_no_extra_accept"}, 64'(n_acc - base), 64'd3);
        take_output(tag);
    endtask

    initial begin
        bit ok;
        int acc_edge, bad;
        logic [255:0] ones;
        ones = row8(1, 1, 1, 1, 1, 1, 1, 1);

        vecs[0] = '{ones, ones, 32'd1, 32'd8, 1'b0};
        vecs[1] = '{row8(1, 2, 3, 4, 5, 6, 7, 8), row8(2, 2, 2, 2, 2, 2, 2, 2), 32'd1, 32'd72, 1'b0};
        vecs[2] = '{row8(1, 2, 3, 4, 5, 6, 7, 8), row8(8, 7, 6, 5, 4, 3, 2, 1), 32'd1, 32'd120, 1'b0};
        vecs[3] = '{row8(-1, -1, -1, -1, -1, -1, -1, -1), row8(1, 2, 3, 4, 5, 6, 7, 8),
                    32'd1, 32'hFFFF_FFDC, 1'b0};
`ifdef DOT_SATURATE_EN
        vecs[4] = '{row8(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                         32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
                    row8(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                         32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
                    32'd1, 32'h7FFF_FFFF, 1'b1};
        vecs[5] = '{row8(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                         32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000),
                    row8(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                         32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
                    32'd1, 32'h8000_0000, 1'b1};
`else
        vecs[4] = '{row8(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                         32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
                    row8(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                         32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
                    32'd1, 32'h0000_0008, 1'b0};
        vecs[5] = '{row8(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                         32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000),
                    row8(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                         32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
                    32'd1, 32'h0000_0000, 1'b0};
`endif
        vecs[6] = '{row8(5, 0, 0, 0, 0, 0, 0, 3), row8(7, 0, 0, 0, 0, 0, 0, -2), 32'd1, 32'd29, 1'b0};
        vecs[7] = '{ones, ones, 32'd0, 32'd8, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(dot_product_output), 64'd0);
        chk("rst_sat", 64'(sat_flag), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        #1;
        chk("rst_release_in_ready_still_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("rst_in_ready_rises", 64'(in_ready), 64'd1);

        // Single-beat vector table
        for (int v = 0; v < 8; v++) begin
            run_single($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].tot,
                       vecs[v].exp_val, vecs[v].exp_sat, 0);
        end

        // Back-to-back beats, then a 5-cycle gap before the third beat
        run_three("three_held", 0);
        run_three("three_gap", 5);

        // Output held with out_ready low for 10 cycles
        run_single("stall", ones, ones, 32'd1, 32'd8, 1'b0, 10);

        // Reset during DRAIN aborts without a result
        wait_ready(ok);
        if (ok) begin
            first_row_input  = ones;
            second_row_input = ones;
            total            = 32'd1;
            in_valid         = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            acc_edge = cyc;
            repeat (5) @(negedge clk);
            chk("drain_busy", 64'(busy), 64'd1);
            chk("drain_no_out", 64'(out_valid), 64'd0);
            reset = 1'b0;
            #1;
            chk("abort_in_ready", 64'(in_ready), 64'd0);
            chk("abort_out_valid", 64'(out_valid), 64'd0);
            chk("abort_result", 64'(dot_product_output), 64'd0);
            chk("abort_sat", 64'(sat_flag), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            repeat (2) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            chk("abort_in_ready_rises", 64'(in_ready), 64'd1);
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
            end
            chk("abort_no_stale_result", 64'(bad), 64'd0);
            run_single("after_abort", ones, ones, 32'd1, 32'd8, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
